// File: rtl/binning_pkg.sv
// Shared types, default geometry and helpers for the K x K binning sequencer.
package binning_pkg;

  // Sequencer states; also driven out on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_e;

  // Default raster geometry and the widths derived from it.
  localparam int HRES_DEF   = 1280;
  localparam int VRES_DEF   = 720;
  localparam int KERNEL_DEF = 4;
  localparam int HWIDTH     = $clog2(HRES_DEF);
  localparam int VWIDTH     = $clog2(VRES_DEF);
  localparam int PHASE_W    = $clog2(KERNEL_DEF);

  // Widest one-hot select the rotate helper handles.
  localparam int MAX_K = 32;

  // Rotate the low k bits of a one-hot vector left by one, MSB wrapping to bit 0.
  // Bits at or above k are returned as zero.
  function automatic logic [MAX_K-1:0] rotl_onehot(input logic [MAX_K-1:0] v,
                                                   input int unsigned      k);
    logic [MAX_K-1:0] r;
    logic [4:0]       idx;
    r = '0;
    for (int i = 0; i < MAX_K; i++) begin
      if (i < k) begin
        idx    = 5'((i + 1) % k);
        r[idx] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/binning_sched_raster_checker.sv
// Raster follower: remembers the expected column and the last row seen, and
// flags start-of-frame, end-of-frame, row advance and raster discontinuities
// for the pixel currently on the inputs.
module raster_checker
  import binning_pkg::*;
#(
  parameter int HRES = HRES_DEF,
  parameter int VRES = VRES_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [$clog2(HRES)-1:0] i_hcount,
  input  logic [$clog2(VRES)-1:0] i_vcount,
  input  logic                    i_update,
  output logic                    o_sof,
  output logic                    o_eof,
  output logic                    o_row_advance,
  output logic                    o_disc
);

  localparam int H_W = $clog2(HRES);
  localparam int V_W = $clog2(VRES);

  logic [H_W-1:0] r_exp_col;
  logic [V_W-1:0] r_last_v;

  logic [V_W:0]   w_v_plus1;
  logic           w_v_is_next;
  logic           w_v_same;
  logic           w_col_ok;
  logic           w_h_zero;
  logic           w_h_last;

  // One wider than the row counter so the last row + 1 never aliases row 0.
  assign w_v_plus1   = {1'b0, r_last_v} + (V_W+1)'(1);
  assign w_v_is_next = ({1'b0, i_vcount} == w_v_plus1);
  assign w_v_same    = (i_vcount == r_last_v);
  assign w_col_ok    = (i_hcount == r_exp_col);
  assign w_h_zero    = (i_hcount == '0);
  assign w_h_last    = (i_hcount == H_W'(HRES - 1));

  assign o_sof         = i_valid & w_h_zero & (i_vcount == '0);
  assign o_eof         = i_valid & w_h_last & (i_vcount == V_W'(VRES - 1));
  assign o_row_advance = i_valid & w_h_zero & w_v_is_next;
  // Wrong column, a row jump other than +1, or a row change before the line finished.
  assign o_disc        = i_valid &
                         (~w_col_ok | (~w_v_same & (~w_v_is_next | (r_exp_col != '0))));

  // Track position of the last accepted pixel; expected column wraps at line end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp_col <= '0;
      r_last_v  <= '0;
    end else if (i_update) begin
      r_exp_col <= w_h_last ? '0 : (i_hcount + H_W'(1));
      r_last_v  <= i_vcount;
    end
  end

endmodule

// File: rtl/binning_sched.sv
// K x K binning sequencer: locks to start-of-frame, rotates the one-hot
// line-buffer write select per row, and issues tile clear/emit strobes with
// binned coordinates. All outputs are registered one cycle after their pixel.
//
// Handshake: data_valid_in qualifies hcount_in/vcount_in for one cycle; there is
// no backpressure, a low data_valid_in is a stall that holds all tracking state.
module binning_sched
  import binning_pkg::*;
#(
  parameter int HRES        = HRES_DEF,
  parameter int VRES        = VRES_DEF,
  parameter int KERNEL_SIZE = KERNEL_DEF
) (
  input  logic                                          clk_in,
  input  logic                                          rst_n_in,
  input  logic                                          enable_in,
  input  logic [$clog2(HRES)-1:0]                       hcount_in,
  input  logic [$clog2(VRES)-1:0]                       vcount_in,
  input  logic                                          data_valid_in,
  output logic [KERNEL_SIZE-1:0]                        wr_sel_out,
  output logic [$clog2(KERNEL_SIZE)-1:0]                row_phase_out,
  output logic [$clog2(KERNEL_SIZE)-1:0]                col_phase_out,
  output logic                                          clear_acc_out,
  output logic                                          emit_out,
  output logic [$clog2(HRES)-$clog2(KERNEL_SIZE)-1:0]   hcount_out,
  output logic [$clog2(VRES)-$clog2(KERNEL_SIZE)-1:0]   vcount_out,
  output logic                                          frame_done_out,
  output logic                                          line_err_out,
  output logic                                          busy_out,
  output state_e                                        dbg_state_out
);

  localparam int H_W = $clog2(HRES);
  localparam int V_W = $clog2(VRES);
  localparam int P_W = $clog2(KERNEL_SIZE);
  localparam logic [P_W-1:0] PH_LAST = P_W'(KERNEL_SIZE - 1);

  // Geometry sanity checks at elaboration.
  if (KERNEL_SIZE < 2 || (KERNEL_SIZE & (KERNEL_SIZE - 1)) != 0) begin : g_chk_k
    $error("binning_sched: KERNEL_SIZE must be a power of two >= 2");
  end
  if (KERNEL_SIZE > MAX_K) begin : g_chk_kmax
    $error("binning_sched: KERNEL_SIZE exceeds MAX_K");
  end
  if (HRES % KERNEL_SIZE != 0) begin : g_chk_h
    $error("binning_sched: HRES must be a multiple of KERNEL_SIZE");
  end
  if (VRES % KERNEL_SIZE != 0) begin : g_chk_v
    $error("binning_sched: VRES must be a multiple of KERNEL_SIZE");
  end

  state_e                 r_state;
  state_e                 w_next_state;

  logic                   w_sof;
  logic                   w_eof;
  logic                   w_row_adv;
  logic                   w_disc;
  logic                   w_accept_sof;
  logic                   w_accept_pix;
  logic                   w_take;
  logic                   w_err;

  logic [KERNEL_SIZE-1:0] r_row_sel;
  logic [KERNEL_SIZE-1:0] w_rot_sel;
  logic [KERNEL_SIZE-1:0] w_sel_now;

  logic [KERNEL_SIZE-1:0] r_wr_sel,   w_wr_sel_d;
  logic [P_W-1:0]         r_row_ph,   w_row_ph_d;
  logic [P_W-1:0]         r_col_ph,   w_col_ph_d;
  logic                   r_clear,    w_clear_d;
  logic                   r_emit,     w_emit_d;
  logic [H_W-P_W-1:0]     r_hbin,     w_hbin_d;
  logic [V_W-P_W-1:0]     r_vbin,     w_vbin_d;
  logic                   r_fdone,    w_fdone_d;
  logic                   r_lerr,     w_lerr_d;

  raster_checker #(
    .HRES (HRES),
    .VRES (VRES)
  ) u_raster_checker (
    .i_clk         (clk_in),
    .i_rst_n       (rst_n_in),
    .i_valid       (data_valid_in),
    .i_hcount      (hcount_in),
    .i_vcount      (vcount_in),
    .i_update      (w_take),
    .o_sof         (w_sof),
    .o_eof         (w_eof),
    .o_row_advance (w_row_adv),
    .o_disc        (w_disc)
  );

  // A pixel is consumed either as the locking SOF or as a clean pixel mid-frame.
  assign w_accept_sof = (r_state == ST_WAIT_SOF) & enable_in & w_sof;
  assign w_accept_pix = (r_state == ST_ACTIVE) & data_valid_in & ~w_disc;
  assign w_take       = w_accept_sof | w_accept_pix;
  assign w_err        = (r_state == ST_ACTIVE) & w_disc;
  assign w_rot_sel    = KERNEL_SIZE'(rotl_onehot(MAX_K'(r_row_sel), KERNEL_SIZE));

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_next_state;
  end

  // Next-state: frames always run to their last pixel unless the raster breaks.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (enable_in) w_next_state = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!enable_in)  w_next_state = ST_IDLE;
        else if (w_sof)  w_next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_disc)     w_next_state = ST_WAIT_SOF;
        else if (w_eof) w_next_state = enable_in ? ST_WAIT_SOF : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode for the current pixel; strobes only for consumed pixels, phases hold otherwise.
  always_comb begin
    w_sel_now = r_row_sel;
    if (w_accept_sof)   w_sel_now = KERNEL_SIZE'(1);
    else if (w_row_adv) w_sel_now = w_rot_sel;

    w_wr_sel_d = '0;
    w_row_ph_d = r_row_ph;
    w_col_ph_d = r_col_ph;
    w_clear_d  = 1'b0;
    w_emit_d   = 1'b0;
    w_hbin_d   = r_hbin;
    w_vbin_d   = r_vbin;
    if (w_take) begin
      w_wr_sel_d = w_sel_now;
      w_row_ph_d = vcount_in[P_W-1:0];
      w_col_ph_d = hcount_in[P_W-1:0];
      w_clear_d  = (hcount_in[P_W-1:0] == '0) & (vcount_in[P_W-1:0] == PH_LAST);
      w_emit_d   = (hcount_in[P_W-1:0] == PH_LAST) & (vcount_in[P_W-1:0] == PH_LAST);
      if (w_emit_d) begin
        w_hbin_d = hcount_in[H_W-1:P_W];
        w_vbin_d = vcount_in[V_W-1:P_W];
      end
    end
    w_fdone_d = w_accept_pix & w_eof;
    w_lerr_d  = w_err;
  end

  // Row select memory: loaded on SOF, rotated on each new row.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   r_row_sel <= '0;
    else if (w_take) r_row_sel <= w_sel_now;
  end

  // Output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_sel <= '0;
      r_row_ph <= '0;
      r_col_ph <= '0;
      r_clear  <= 1'b0;
      r_emit   <= 1'b0;
      r_hbin   <= '0;
      r_vbin   <= '0;
      r_fdone  <= 1'b0;
      r_lerr   <= 1'b0;
    end else begin
      r_wr_sel <= w_wr_sel_d;
      r_row_ph <= w_row_ph_d;
      r_col_ph <= w_col_ph_d;
      r_clear  <= w_clear_d;
      r_emit   <= w_emit_d;
      r_hbin   <= w_hbin_d;
      r_vbin   <= w_vbin_d;
      r_fdone  <= w_fdone_d;
      r_lerr   <= w_lerr_d;
    end
  end

  assign wr_sel_out     = r_wr_sel;
  assign row_phase_out  = r_row_ph;
  assign col_phase_out  = r_col_ph;
  assign clear_acc_out  = r_clear;
  assign emit_out       = r_emit;
  assign hcount_out     = r_hbin;
  assign vcount_out     = r_vbin;
  assign frame_done_out = r_fdone;
  assign line_err_out   = r_lerr;
  assign busy_out       = (r_state == ST_ACTIVE);
  assign dbg_state_out  = r_state;

endmodule

// File: tb/tb_binning_sched.sv
// Directed bench for binning_sched on an 8x8 raster with 4x4 tiles.
module tb_binning_sched;
  import binning_pkg::*;

  localparam int PW = 14;

  logic       clk_in;
  logic       rst_n_in;
  logic       enable_in;
  logic [2:0] hcount_in;
  logic [2:0] vcount_in;
  logic       data_valid_in;
  logic [3:0] wr_sel_out;
  logic [1:0] row_phase_out;
  logic [1:0] col_phase_out;
  logic       clear_acc_out;
  logic       emit_out;
  logic [0:0] hcount_out;
  logic [0:0] vcount_out;
  logic       frame_done_out;
  logic       line_err_out;
  logic       busy_out;
  state_e     dbg_state_out;

  binning_sched #(
    .HRES        (8),
    .VRES        (8),
    .KERNEL_SIZE (4)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .enable_in      (enable_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .wr_sel_out     (wr_sel_out),
    .row_phase_out  (row_phase_out),
    .col_phase_out  (col_phase_out),
    .clear_acc_out  (clear_acc_out),
    .emit_out       (emit_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .frame_done_out (frame_done_out),
    .line_err_out   (line_err_out),
    .busy_out       (busy_out),
    .dbg_state_out  (dbg_state_out)
  );

  // Clock / reset block
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int tests_run    = 0;
  int tests_failed = 0;
  int n_emit       = 0;
  int n_fd         = 0;

  // Scoreboard: packed {wr_sel, row_ph, col_ph, clear, emit, hbin, vbin, frame_done, line_err}
  logic [PW-1:0] exp_q[$];
  logic [1:0]    m_rp = '0;
  logic [1:0]    m_cp = '0;
  logic          m_ho = 1'b0;
  logic          m_vo = 1'b0;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] outs_now();
    return {wr_sel_out, row_phase_out, col_phase_out, clear_acc_out, emit_out,
            hcount_out, vcount_out, frame_done_out, line_err_out};
  endfunction

  // Driver: present one input cycle, predict its registered result, compare after the edge.
  task automatic step(input logic vld, input int h, input int v, input logic taken,
                      input logic fd, input logic le, input logic bsy);
    logic [3:0]    ws;
    logic          cl, em;
    logic [PW-1:0] e;
    data_valid_in = vld;
    hcount_in     = 3'(h);
    vcount_in     = 3'(v);
    ws = '0; cl = 1'b0; em = 1'b0;
    if (taken) begin
      m_rp = 2'(v % 4);
      m_cp = 2'(h % 4);
      ws   = 4'(1 << (v % 4));
      cl   = (h % 4 == 0) && (v % 4 == 3);
      em   = (h % 4 == 3) && (v % 4 == 3);
      if (em) begin
        m_ho = 1'(h / 4);
        m_vo = 1'(v / 4);
      end
    end
    exp_q.push_back({ws, m_rp, m_cp, cl, em, m_ho, m_vo, fd, le});
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check($sformatf("px h%0d v%0d vld%0d", h, v, vld), outs_now(), e);
    check($sformatf("busy h%0d v%0d", h, v), PW'(busy_out), PW'(bsy));
    if (emit_out) n_emit++;
    if (frame_done_out) n_fd++;
  endtask

  task automatic stall(input logic bsy);
    step(1'b0, $urandom_range(0, 7), $urandom_range(0, 7), 1'b0, 1'b0, 1'b0, bsy);
  endtask

  task automatic px_ok(input int h, input int v);
    step(1'b1, h, v, 1'b1, (h == 7 && v == 7), 1'b0, !(h == 7 && v == 7));
  endtask

  task automatic px_dead(input int h, input int v);
    step(1'b1, h, v, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic px_err(input int h, input int v);
    step(1'b1, h, v, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Raster pixels from (h0,v0) to the end of the frame, all expected to be ignored.
  task automatic dead_from(input int h0, input int v0);
    for (int idx = v0 * 8 + h0; idx < 64; idx++) px_dead(idx % 8, idx / 8);
  endtask

  task automatic full_frame(input bit gaps, input int drop_h, input int drop_v);
    n_emit = 0;
    n_fd   = 0;
    for (int v = 0; v < 8; v++) begin
      for (int h = 0; h < 8; h++) begin
        if (gaps && $urandom_range(0, 1) == 1) stall(!(h == 0 && v == 0));
        if (h == drop_h && v == drop_v) enable_in = 1'b0;
        px_ok(h, v);
      end
    end
    check("emit_count", PW'(n_emit), PW'(4));
    check("frame_done_count", PW'(n_fd), PW'(1));
  endtask

  initial begin
    rst_n_in      = 1'b0;
    enable_in     = 1'b0;
    data_valid_in = 1'b0;
    hcount_in     = '0;
    vcount_in     = '0;

    // Reset state
    #12;
    check("reset_outs", outs_now(), '0);
    check("reset_busy", PW'(busy_out), '0);
    check("reset_state", PW'(dbg_state_out), PW'(ST_IDLE));
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Clean frame, continuous valid
    enable_in = 1'b1;
    stall(1'b0);
    check("wait_sof_state", PW'(dbg_state_out), PW'(ST_WAIT_SOF));
    full_frame(1'b0, -1, -1);

    // Same frame with random valid gaps
    full_frame(1'b1, -1, -1);

    // Skipped row: v jumps 2 -> 4 at h0
    n_emit = 0;
    for (int v = 0; v < 3; v++) for (int h = 0; h < 8; h++) px_ok(h, v);
    px_err(0, 4);
    check("skip_state", PW'(dbg_state_out), PW'(ST_WAIT_SOF));
    dead_from(1, 4);
    check("skip_no_emit", PW'(n_emit), '0);
    full_frame(1'b0, -1, -1);

    // enable dropped mid-frame: frame completes, then idle and ignores the next frame
    full_frame(1'b0, 4, 2);
    check("drop_state", PW'(dbg_state_out), PW'(ST_IDLE));
    n_emit = 0;
    dead_from(0, 0);
    check("drop_no_emit", PW'(n_emit), '0);

    // Asynchronous reset mid-frame
    enable_in = 1'b1;
    stall(1'b0);
    for (int idx = 0; idx < 5 * 8 + 5; idx++) px_ok(idx % 8, idx / 8);
    data_valid_in = 1'b1;
    hcount_in     = 3'd5;
    vcount_in     = 3'd5;
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_rst_outs", outs_now(), '0);
    check("async_rst_busy", PW'(busy_out), '0);
    check("async_rst_state", PW'(dbg_state_out), PW'(ST_IDLE));
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    data_valid_in = 1'b0;
    rst_n_in      = 1'b1;
    m_rp = '0; m_cp = '0; m_ho = 1'b0; m_vo = 1'b0;
    stall(1'b0);
    dead_from(6, 5);
    full_frame(1'b0, -1, -1);

    // Short line: row 1 ends at h5, then v2 h0
    n_fd = 0;
    for (int h = 0; h < 8; h++) px_ok(h, 0);
    for (int h = 0; h < 6; h++) px_ok(h, 1);
    px_err(0, 2);
    dead_from(1, 2);
    check("short_no_frame_done", PW'(n_fd), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/binning_sched.md
Name: binning_sched

Overview:
- Control/sequencing block for the K x K binning datapath.
- Watches the incoming pixel raster (hcount/vcount/valid), locks to start-of-frame and rotates the one-hot line-buffer write select on every new row.
- Tracks row/column phase inside each K x K tile, and issues accumulator-clear and emit strobes plus the binned output coordinates.
- Detects raster discontinuities and resynchronises. Sits between the camera/threshold stage and the line-buffer/accumulator datapath.

Parameters:
- HRES, 1280, active pixels per line; must be a multiple of KERNEL_SIZE (elaboration-time assertion).
- VRES, 720, active lines per frame; must be a multiple of KERNEL_SIZE (elaboration-time assertion).
- KERNEL_SIZE, 4, tile edge; power of two, at least 2.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- enable_in  input  1  request binning; sampled only at start-of-frame
- hcount_in  input  $clog2(HRES)  column of incoming pixel
- vcount_in  input  $clog2(VRES)  row of incoming pixel
- data_valid_in  input  1  incoming pixel valid
- wr_sel_out  output  KERNEL_SIZE  one-hot line-buffer write enable
- row_phase_out  output  $clog2(KERNEL_SIZE)  vcount mod K of current pixel
- col_phase_out  output  $clog2(KERNEL_SIZE)  hcount mod K of current pixel
- clear_acc_out  output  1  first pixel of a tile's last row (col_phase 0, row_phase K-1)
- emit_out  output  1  last pixel of tile (both phases K-1)
- hcount_out  output  $clog2(HRES)-$clog2(KERNEL_SIZE)  binned column, valid with emit_out
- vcount_out  output  $clog2(VRES)-$clog2(KERNEL_SIZE)  binned row, valid with emit_out
- frame_done_out  output  1  one-cycle pulse after last pixel of a binned frame
- line_err_out  output  1  one-cycle pulse on raster discontinuity
- busy_out  output  1  high while in ACTIVE

Behaviour:
- States: IDLE, WAIT_SOF, ACTIVE.
- IDLE -> WAIT_SOF when enable_in=1.
- WAIT_SOF -> ACTIVE on SOF, defined as data_valid_in & hcount_in==0 & vcount_in==0, with enable_in=1. If enable_in=0 in WAIT_SOF, return to IDLE.
- ACTIVE -> WAIT_SOF on the last pixel (valid, hcount HRES-1, vcount VRES-1). That same cycle sets frame_done_out=1 next cycle. If enable_in=0 at that point, go to IDLE instead.
- enable_in deassert mid-frame has no effect until the frame ends; frames are never truncated.
- All outputs are registered, with 1-cycle latency relative to the qualifying input pixel. The datapath delays its pixel by one stage to align.
- In any state other than ACTIVE, the outputs are wr_sel_out=0, emit_out=0 and clear_acc_out=0; phases hold.
- Row tracking:
  - The block stores last_vcount and the expected column.
  - On the SOF pixel, wr_sel is set to bit 0.
  - On a valid pixel with vcount_in==last_vcount+1 and hcount_in==0, wr_sel rotates left by one, wrapping MSB to bit 0.
- Discontinuity, checked only in ACTIVE on valid pixels:
  - Error conditions: hcount_in != expected column; a vcount change that is not +1; or a vcount change while the expected column is nonzero (short line).
  - Response: line_err_out pulses, the block goes to WAIT_SOF, and the offending pixel produces no wr_sel, emit or clear. A discontinuous SOF pixel that arrives mid-frame is not itself reused as SOF; the block waits for the next SOF.
- Expected column increments per valid pixel and wraps HRES-1 -> 0.
- data_valid_in=0 cycles are stalls: counters hold and strobe outputs are 0.
- Phases equal the low log2(K) bits of the pixel's hcount/vcount. hcount_out and vcount_out are the upper bits (hcount_in >> log2 K), registered with emit_out; no arithmetic beyond shifts.
- Reset: all outputs 0; state IDLE; wr_sel=0; last_vcount=0. Asserting reset mid-frame clears immediately, asynchronously; release is synchronous to clk_in.
- Simultaneous events: the last pixel with a discontinuity reports line_err only (no frame_done). When K divides the resolution, the last pixel always produces emit and frame_done together.

Decomposition:
- Package binning_pkg: state enum (IDLE/WAIT_SOF/ACTIVE), localparams for HWIDTH, VWIDTH, PHASE_W = $clog2(KERNEL_SIZE), and function rotl_onehot.
- One natural sub-module, raster_checker: tracks the expected h/v and emits sof, eof, row_advance and discontinuity flags. The FSM and strobe generation stay in the top level.

Test Plan:
All cases use HRES=8, VRES=8, K=4.
- Clean frame, enable_in=1, continuous valid:
  - wr_sel_out sequence per row is 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
  - emit_out pulses exactly 4 times, at (h3,v3), (h7,v3), (h3,v7), (h7,v7), giving out coords (0,0), (1,0), (0,1), (1,1).
  - frame_done_out pulses once, 1 cycle after pixel (7,7).
- Random valid gaps (50% duty) over the same frame -> identical emit/coord sequence; no strobe on invalid cycles.
- Skip row: vcount jumps 2 -> 4 at h0 -> line_err_out 1 pulse, busy_out drops, no further emits until the next SOF, then a normal frame.
- enable_in dropped at (4,2) -> frame completes with all 4 emits, then IDLE; the next frame produces no wr_sel activity.
- rst_n_in low at (5,5) mid-frame -> all outputs 0 asynchronously (before next edge); after release with enable_in high, the block waits for SOF and then bins the next frame correctly.
- Short line: row 1 ends at h5 then v2 h0 -> line_err_out pulse; no frame_done_out for that frame.
